// File: rtl/prio_enc_hs.sv
// Sticky-pending priority encoder with a valid/ready output handshake.
// Define PRIO_ENC_RR_EN to replace fixed priority with a round-robin pointer.
module prio_enc_hs #(
  parameter int unsigned N = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N-1:0]                         req_in,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_idx,
  output logic [N-1:0]                         out_onehot,
  output logic [N-1:0]                         pend,
  output logic                                 dropped
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_d;
  logic           valid_d;
  logic [W-1:0]   idx_d;
  logic [N-1:0]   onehot_d;
  logic           dropped_d;

  logic           handshake_c;
  logic [N-1:0]   clr_c;
  logic [N-1:0]   cand_c;
  logic           load_c;
  logic [W-1:0]   win_idx_c;
  logic [N-1:0]   win_onehot_c;

`ifdef PRIO_ENC_RR_EN
  localparam int unsigned W2 = $clog2(2 * N);

  logic [W-1:0]   ptr_q, ptr_d;
  logic [2*N-1:0] cand2_c;
  logic [W2-1:0]  pos_c;
  logic           found_c;
`endif

  // Handshake, clear mask and candidate set; the presented line is masked out.
  always_comb begin
    handshake_c = out_valid & out_ready;
    clr_c       = handshake_c ? out_onehot : '0;
    cand_c      = pend & ~(out_valid ? out_onehot : '0);
    load_c      = (state_q == IDLE) | handshake_c;
  end

`ifdef PRIO_ENC_RR_EN
  // Round-robin: first set bit at or below ptr, wrapping from 0 back to N-1.
  always_comb begin
    win_idx_c = '0;
    found_c   = 1'b0;
    pos_c     = '0;
    cand2_c   = {cand_c, cand_c};
    for (int i = 0; i < N; i++) begin
      pos_c = W2'(int'(ptr_q) + N - i);
      if (!found_c && cand2_c[pos_c]) begin
        found_c   = 1'b1;
        win_idx_c = (pos_c >= W2'(N)) ? W'(pos_c - W2'(N)) : W'(pos_c);
      end
    end
  end
`else
  // Fixed priority: highest set index wins.
  always_comb begin
    win_idx_c = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_c[i]) win_idx_c = W'(i);
    end
  end
`endif

  assign win_onehot_c = {{(N-1){1'b0}}, 1'b1} << win_idx_c;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    valid_d   = out_valid;
    idx_d     = out_idx;
    onehot_d  = out_onehot;
    pend_d    = (pend & ~clr_c) | req_in;
    dropped_d = |(req_in & pend & ~clr_c);
`ifdef PRIO_ENC_RR_EN
    ptr_d     = ptr_q;
    if (handshake_c) ptr_d = (out_idx == '0) ? W'(N - 1) : out_idx - W'(1);
`endif
    if (load_c) begin
      valid_d  = |cand_c;
      idx_d    = (|cand_c) ? win_idx_c : '0;
      onehot_d = (|cand_c) ? win_onehot_c : '0;
    end
    case (state_q)
      IDLE:    if (|cand_c) state_d = HOLD;
      HOLD:    if (handshake_c && !(|cand_c)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend       <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      dropped    <= 1'b0;
`ifdef PRIO_ENC_RR_EN
      ptr_q      <= W'(N - 1);
`endif
    end else begin
      state_q    <= state_d;
      pend       <= pend_d;
      out_valid  <= valid_d;
      out_idx    <= idx_d;
      out_onehot <= onehot_d;
      dropped    <= dropped_d;
`ifdef PRIO_ENC_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_prio_enc_hs.sv
// Directed bench for prio_enc_hs (N=8); expectations follow PRIO_ENC_RR_EN.
module tb_prio_enc_hs;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_in;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic [N-1:0] pend;
  logic         dropped;

  int checks = 0;
  int errors = 0;

  prio_enc_hs #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pend       (pend),
    .dropped    (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = '0; out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got %0d exp 0", out_idx); end
    checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL rst_onehot got %h exp 00", out_onehot); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL rst_pend got %h exp 00", pend); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL rst_dropped got %b exp 0", dropped); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL idle_pend got %h exp 00", pend); end
  endtask

  task automatic test_basic();
    req_in = 8'h05; out_ready = 1'b1;
    tick();
    checks++; if (pend !== 8'h05) begin errors++; $display("FAIL basic_pend got %h exp 05", pend); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat got %b exp 0", out_valid); end
    req_in = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd2) begin errors++; $display("FAIL basic_first got v=%b idx=%0d exp v=1 idx=2", out_valid, out_idx); end
    checks++; if (out_onehot !== 8'h04) begin errors++; $display("FAIL basic_onehot got %h exp 04", out_onehot); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin errors++; $display("FAIL basic_second got v=%b idx=%0d exp v=1 idx=0", out_valid, out_idx); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_onehot !== 8'h00) begin errors++; $display("FAIL basic_idle got v=%b oh=%h exp v=0 oh=00", out_valid, out_onehot); end
    checks++; if (pend !== 8'h00) begin errors++; $display("FAIL basic_pend_end got %h exp 00", pend); end
    out_ready = 1'b0;
  endtask

  task automatic test_hold();
    out_ready = 1'b0; req_in = 8'h80;
    tick();
    req_in = 8'h01;
    tick();
    req_in = '0;
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd7) begin errors++; $display("FAIL hold_load got v=%b idx=%0d exp v=1 idx=7", out_valid, out_idx); end
    repeat (2) tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_onehot !== 8'h80) begin errors++; $display("FAIL hold_stable got v=%b idx=%0d oh=%h exp v=1 idx=7 oh=80", out_valid, out_idx, out_onehot); end
    checks++; if (pend !== 8'h81) begin errors++; $display("FAIL hold_pend got %h exp 81", pend); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin errors++; $display("FAIL hold_next got v=%b idx=%0d exp v=1 idx=0", out_valid, out_idx); end
    checks++; if (pend !== 8'h01) begin errors++; $display("FAIL hold_pend2 got %h exp 01", pend); end
    tick();
    checks++; if (out_valid !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL hold_idle got v=%b pend=%h exp v=0 pend=00", out_valid, pend); end
    out_ready = 1'b0;
  endtask

  task automatic test_dropped();
    out_ready = 1'b0; req_in = 8'h80;
    tick();
    req_in = '0;
    tick();
    req_in = 8'h08;
    tick();
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL drop_first got %b exp 0", dropped); end
    checks++; if (pend !== 8'h88) begin errors++; $display("FAIL drop_pend got %h exp 88", pend); end
    tick();
    req_in = '0;
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", dropped); end
    tick();
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL drop_clear got %b exp 0", dropped); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin errors++; $display("FAIL drop_next got v=%b idx=%0d exp v=1 idx=3", out_valid, out_idx); end
    tick();
    checks++; if (out_valid !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL drop_idle got v=%b pend=%h exp v=0 pend=00", out_valid, pend); end
    out_ready = 1'b0;
  endtask

  task automatic test_set_wins();
    out_ready = 1'b0; req_in = 8'h08;
    tick();
    req_in = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin errors++; $display("FAIL sw_load got v=%b idx=%0d exp v=1 idx=3", out_valid, out_idx); end
    out_ready = 1'b1; req_in = 8'h08;
    tick();
    req_in = '0;
    checks++; if (pend !== 8'h08) begin errors++; $display("FAIL sw_pend got %h exp 08", pend); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL sw_dropped got %b exp 0", dropped); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sw_reload got %b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin errors++; $display("FAIL sw_again got v=%b idx=%0d exp v=1 idx=3", out_valid, out_idx); end
    tick();
    checks++; if (out_valid !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL sw_idle got v=%b pend=%h exp v=0 pend=00", out_valid, pend); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_idx [9];
`ifdef PRIO_ENC_RR_EN
    exp_idx = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
    exp_idx = '{3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
`endif
    req_in = 8'hFF; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_idx !== exp_idx[k]) begin errors++; $display("FAIL stream_%0d got v=%b idx=%0d exp v=1 idx=%0d", k, out_valid, out_idx, exp_idx[k]); end
      checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL stream_drop_%0d got %b exp 1", k, dropped); end
    end
    req_in = '0; out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    req_in = 8'h0C; out_ready = 1'b0;
    tick();
    req_in = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || pend !== 8'h0C) begin errors++; $display("FAIL mr_setup got v=%b idx=%0d pend=%h exp v=1 idx=3 pend=0c", out_valid, out_idx, pend); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_onehot !== 8'h00) begin errors++; $display("FAIL mr_out got v=%b idx=%0d oh=%h exp all 0", out_valid, out_idx, out_onehot); end
    checks++; if (pend !== 8'h00 || dropped !== 1'b0) begin errors++; $display("FAIL mr_pend got pend=%h drop=%b exp 00 0", pend, dropped); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || pend !== 8'h00) begin errors++; $display("FAIL mr_after_%0d got v=%b pend=%h exp v=0 pend=00", k, out_valid, pend); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_in = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_dropped();
    test_set_wins();
    test_stream();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_enc_hs.md
PRIO_ENC_HS -- requirements
Module: prio_enc_hs

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N, default 8, giving the number of request inputs (legal range 2..64).
REQ-002 The block SHALL derive localparam W = max(1, clog2(N)) as the index width; N need not be a power of two.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: asynchronous assertion and active-low.
REQ-005 The block SHALL have port req_in, input, N, per-line request pulses or levels; bit i means "line i wants service".
REQ-006 The block SHALL have port out_ready, input, 1, consumer accepts the presented index this cycle.
REQ-007 The block SHALL have port out_valid, output, 1, out_idx/out_onehot hold a granted request.
REQ-008 The block SHALL have port out_idx, output, W, binary index of the granted line.
REQ-009 The block SHALL have port out_onehot, output, N, one-hot form of out_idx; all zero when out_valid=0.
REQ-010 The block SHALL have port pend, output, N, the sticky pending-request register.
REQ-011 The block SHALL have port dropped, output, 1, one-cycle pulse: a request arrived on an already-pending line.

Function
REQ-012 The block SHALL define handshake = out_valid & out_ready, and clr = out_onehot when handshake, else zero.
REQ-013 The block SHALL update pend each cycle as pend <= (pend & ~clr) | req_in; when a set and a clear hit the same bit, the set wins.
REQ-014 The block SHALL form eligible candidates as cand = pend & ~(out_valid ? out_onehot : 0); the presented line is never re-selected on its own reload cycle.
REQ-015 The block SHALL use a 2-state output FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-016 The output register SHALL load only in IDLE, or in HOLD on handshake; on load, out_valid <= |cand, and the winner of cand is registered into out_idx/out_onehot.
REQ-017 From HOLD, the FSM SHALL go to IDLE when cand=0 on handshake, and otherwise remain in HOLD.
REQ-018 In HOLD without out_ready, out_valid/out_idx/out_onehot SHALL remain stable.
REQ-019 Fixed-priority selection SHALL give the winner as the highest set index of cand.
REQ-020 Latency SHALL be: req_in at edge t is in pend after t+1; from IDLE, out_valid=1 with that index after t+2.
REQ-021 dropped SHALL be registered |(req_in & pend & ~clr), asserted the cycle after the event, and SHALL NOT be raised for a set-wins collision with clr.
REQ-022 With req_in=0 and pend=0, the block SHALL sit in IDLE with out_valid=0 indefinitely.

Reset
REQ-023 On rst_n low, the block SHALL immediately set pend=0, out_valid=0, out_idx=0, out_onehot=0, dropped=0, the FSM to IDLE, and the RR pointer to N-1.
REQ-024 A reset asserted mid-transaction SHALL discard the held grant and all pending requests; nothing is replayed after rst_n rises.
REQ-025 The first load SHALL NOT occur before the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 When the macro PRIO_ENC_RR_EN is defined, the block SHALL add a W-bit pointer ptr; the winner is the first set bit of cand searching downward from ptr, wrapping from 0 to N-1.
REQ-027 With PRIO_ENC_RR_EN defined, on each handshake of index k, the block SHALL set ptr <= (k==0) ? N-1 : k-1.
REQ-028 Without PRIO_ENC_RR_EN, the block SHALL have no ptr logic, and selection SHALL be pure fixed priority per REQ-019.

Verification (N=8)
REQ-029 Reset then req_in=8'h05 for 1 cycle with out_ready=1 SHALL give out_valid=1, idx=2 at t+2; idx=0 at t+3; out_valid=0 at t+4; pend=0.
REQ-030 With out_ready=0, req_in=8'h80 then 8'h01 SHALL hold idx=7 stable with pend=8'h81; raising out_ready SHALL give idx=0 next, then IDLE.
REQ-031 req_in bit3 at t, then again at t+1 with out_ready=0 and bit7 pending, SHALL give dropped=1 for exactly one cycle at t+2.
REQ-032 req_in=8'hFF held, out_ready=1: without PRIO_ENC_RR_EN, idx SHALL be 7,6,7,6,...; with it, idx SHALL be 7,6,5,4,3,2,1,0,7.
REQ-033 With out_valid=1, idx=3, pend=8'h0C, pulsing rst_n low mid-cycle SHALL immediately zero all outputs; out_valid SHALL stay 0 after release until a new req_in.
